// File: rtl/sobel_pkg.sv
`default_nettype none
// sobel_pkg (rev 1.0): FSM state encoding and PixCol3x1 tap ordering shared by
// the Sobel window controller and the Sobel datapath bench.
package sobel_pkg;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    RUN      = 2'd1,
    DRAIN    = 2'd2
  } state_e;

  localparam int TAP_Y2 = 0;
  localparam int TAP_Y1 = 1;
  localparam int TAP_Y0 = 2;

endpackage
`default_nettype wire

// File: rtl/sobel_line_buf.sv
`default_nettype none
// sobel_line_buf (rev 1.0): two stacked line buffers with synchronous read;
// a write pushes the new pixel into row y-1 and shifts the old y-1 value down to y-2.
module sobel_line_buf
  import sobel_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 640,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] row1_o,
  output logic [DATA_W-1:0] row2_o
);

  logic [DATA_W-1:0] lb0_q [DEPTH];
  logic [DATA_W-1:0] lb1_q [DEPTH];
  logic [DATA_W-1:0] rd0_q;
  logic [DATA_W-1:0] rd1_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      lb0_q[addr_i] <= din_i;
      lb1_q[addr_i] <= lb0_q[addr_i];
    end
  end

  // Read ports see the pre-write contents, so the column lines up with the new pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd0_q <= '0;
      rd1_q <= '0;
    end else if (en_i) begin
      rd0_q <= lb0_q[addr_i];
      rd1_q <= lb1_q[addr_i];
    end
  end

  assign row1_o = rd0_q;
  assign row2_o = rd1_q;

endmodule
`default_nettype wire

// File: rtl/sobel_window_ctrl.sv
`default_nettype none
// sobel_window_ctrl (rev 1.0): raster-scan sequencer feeding 3x1 columns to the Sobel
// datapath and qualifying its results. Optional macro: SOBEL_STALL_CNT_EN (stall counter).
module sobel_window_ctrl
  import sobel_pkg::*;
#(
  parameter int dataW = 8,
  parameter int imgW  = 640,
  parameter int imgH  = 480,
  parameter int xW    = $clog2(imgW),
  parameter int yW    = $clog2(imgH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_valid,
  input  logic               pix_sof,
  input  logic [dataW-1:0]   pix_data,
  output logic               pix_ready,
  output logic [3*dataW-1:0] PixCol3x1,
  output logic               sobel_en,
  output logic               edge_valid,
  input  logic               edge_ready,
  output logic [xW-1:0]      edge_x,
  output logic [yW-1:0]      edge_y,
  output logic               frame_done,
  output logic               frame_err,
  output logic [31:0]        stall_cnt
);

  localparam logic [xW-1:0] LAST_COL = xW'(imgW - 1);
  localparam logic [yW-1:0] LAST_ROW = yW'(imgH - 1);

  state_e           state_q, state_d;
  logic [xW-1:0]    col_q, col_d, s1_col_q, edge_x_q, load_col;
  logic [yW-1:0]    row_q, row_d, s1_row_q, edge_y_q, load_row;
  logic             s1_valid_q, edge_valid_q, frame_done_q, frame_done_d, frame_err_q;
  logic [dataW-1:0] s1_pix_q, lb_y1, lb_y2;
  logic             stall, sobel_en_w, ready_w, accept, take_sof, abort, load, last_pix, qualify;

  assign stall      = edge_valid_q && !edge_ready;
  assign sobel_en_w = s1_valid_q && !stall;

  always_comb begin
    ready_w = 1'b0;
    case (state_q)
      WAIT_SOF: ready_w = 1'b1;
      RUN:      ready_w = !s1_valid_q || sobel_en_w;
      default:  ready_w = 1'b0;
    endcase
  end

  assign accept   = pix_valid && ready_w;
  assign take_sof = accept && pix_sof;
  assign abort    = take_sof && (state_q != WAIT_SOF);
  // Pixels without sof while waiting for a frame are swallowed without entering the pipe.
  assign load     = accept && (pix_sof || (state_q != WAIT_SOF));
  assign load_col = pix_sof ? '0 : col_q;
  assign load_row = pix_sof ? '0 : row_q;
  assign last_pix = (load_col == LAST_COL) && (load_row == LAST_ROW);
  assign qualify  = sobel_en_w && (s1_col_q >= xW'(2)) && (s1_row_q >= yW'(2));

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    frame_done_d = 1'b0;
    if (load) begin
      if (last_pix) begin
        state_d = DRAIN;
        col_d   = '0;
        row_d   = '0;
      end else begin
        state_d = RUN;
        if (load_col == LAST_COL) begin
          col_d = '0;
          row_d = load_row + 1'b1;
        end else begin
          col_d = load_col + 1'b1;
          row_d = load_row;
        end
      end
    end else if ((state_q == DRAIN) && !s1_valid_q && !edge_valid_q) begin
      state_d      = WAIT_SOF;
      frame_done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WAIT_SOF;
      col_q        <= '0;
      row_q        <= '0;
      s1_valid_q   <= 1'b0;
      s1_pix_q     <= '0;
      s1_col_q     <= '0;
      s1_row_q     <= '0;
      edge_valid_q <= 1'b0;
      edge_x_q     <= '0;
      edge_y_q     <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      frame_done_q <= frame_done_d && !abort;
      frame_err_q  <= abort;
      if (load) begin
        s1_valid_q <= 1'b1;
        s1_pix_q   <= pix_data;
        s1_col_q   <= load_col;
        s1_row_q   <= load_row;
      end else if (sobel_en_w) begin
        s1_valid_q <= 1'b0;
      end
      // A restart drops whatever result the old frame was about to present.
      if (abort) begin
        edge_valid_q <= 1'b0;
      end else if (qualify) begin
        edge_valid_q <= 1'b1;
        edge_x_q     <= s1_col_q - 1'b1;
        edge_y_q     <= s1_row_q - 1'b1;
      end else if (edge_ready) begin
        edge_valid_q <= 1'b0;
      end
    end
  end

  sobel_line_buf #(
    .DATA_W (dataW),
    .DEPTH  (imgW),
    .ADDR_W (xW)
  ) u_line_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (load),
    .addr_i (load_col),
    .din_i  (pix_data),
    .row1_o (lb_y1),
    .row2_o (lb_y2)
  );

  always_comb begin
    PixCol3x1 = '0;
    PixCol3x1[TAP_Y2*dataW +: dataW] = lb_y2;
    PixCol3x1[TAP_Y1*dataW +: dataW] = lb_y1;
    PixCol3x1[TAP_Y0*dataW +: dataW] = s1_pix_q;
  end

`ifdef SOBEL_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (take_sof) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

  assign pix_ready  = ready_w;
  assign sobel_en   = sobel_en_w;
  assign edge_valid = edge_valid_q;
  assign edge_x     = edge_x_q;
  assign edge_y     = edge_y_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_sobel_window_ctrl.sv
`default_nettype none
// tb_sobel_window_ctrl (rev 1.0): self-checking bench for sobel_window_ctrl on a 5x4 image,
// directed scenarios plus randomized handshakes against a raster-order reference model.
module tb_sobel_window_ctrl;

  localparam int W   = 5;
  localparam int H   = 4;
  localparam int NP  = W * H;
  localparam int NFR = 3;
`ifdef SOBEL_STALL_CNT_EN
  localparam int STALL_ON = 1;
`else
  localparam int STALL_ON = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_valid = 1'b0;
  logic        pix_sof = 1'b0;
  logic [7:0]  pix_data = 8'd0;
  logic        edge_ready = 1'b1;
  logic        pix_ready, sobel_en, edge_valid, frame_done, frame_err;
  logic [23:0] PixCol3x1;
  logic [2:0]  edge_x;
  logic [1:0]  edge_y;
  logic [31:0] stall_cnt;

  int   errors = 0;
  int   checks = 0;
  logic acc;

  sobel_window_ctrl #(.dataW(8), .imgW(W), .imgH(H)) dut (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_data(pix_data),
    .pix_ready(pix_ready), .PixCol3x1(PixCol3x1), .sobel_en(sobel_en), .edge_valid(edge_valid),
    .edge_ready(edge_ready), .edge_x(edge_x), .edge_y(edge_y), .frame_done(frame_done),
    .frame_err(frame_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [7:0] pixval(input int idx);
    return 8'((idx % W) * 10 + idx / W);
  endfunction

  // Drive inputs on the falling edge, then let outputs settle before sampling.
  task automatic tick(input logic v, input logic s, input logic [7:0] d, input logic r);
    @(negedge clk);
    pix_valid  = v;
    pix_sof    = s;
    pix_data   = d;
    edge_ready = r;
    #1;
    acc = v && pix_ready;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (pix_ready !== 1'b1) begin errors++; $display("FAIL rst_pix_ready: got %b expected 1", pix_ready); end
    checks++; if (sobel_en !== 1'b0) begin errors++; $display("FAIL rst_sobel_en: got %b expected 0", sobel_en); end
    checks++; if (edge_valid !== 1'b0) begin errors++; $display("FAIL rst_edge_valid: got %b expected 0", edge_valid); end
    checks++; if ({edge_x, edge_y} !== 5'd0) begin errors++; $display("FAIL rst_edge_xy: got %0d,%0d expected 0,0", edge_x, edge_y); end
    checks++; if ({frame_done, frame_err} !== 2'b00) begin errors++; $display("FAIL rst_frame_flags: got %b%b expected 00", frame_done, frame_err); end
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL rst_stall_cnt: got %0d expected 0", stall_cnt); end
    checks++; if (PixCol3x1 !== 24'd0) begin errors++; $display("FAIL rst_pixcol: got %h expected 0", PixCol3x1); end
    rst_n = 1'b1;
  endtask

  task automatic test_no_sof();
    for (int t = 0; t < 10; t++) begin
      tick(t < 8, 1'b0, 8'($urandom), 1'b1);
      checks++;
      if (pix_ready !== 1'b1 || sobel_en !== 1'b0 || edge_valid !== 1'b0) begin
        errors++;
        $display("FAIL nosof_t%0d: got ready=%b sobel_en=%b edge_valid=%b expected 1,0,0", t, pix_ready, sobel_en, edge_valid);
      end
    end
  endtask

  task automatic test_full_frame();
    int k = 0, t12 = -100, first_se = -1, first_ev = -1, nres = 0, nfd = 0, fd_t = -1, last_ev = -1;
    logic [2:0] ex;
    logic [1:0] ey;
    for (int t = 0; t < 40; t++) begin
      tick(k < NP, k == 0, pixval(k), 1'b1);
      if (sobel_en && first_se < 0) first_se = t;
      if (edge_valid && first_ev < 0) first_ev = t;
      if (t == t12 + 1) begin
        checks++;
        if (PixCol3x1 !== {8'd22, 8'd21, 8'd20}) begin errors++; $display("FAIL full_pixcol_2_2: got %h expected 161514", PixCol3x1); end
      end
      if (edge_valid) begin
        ex = 3'(1 + nres % (W - 2));
        ey = 2'(1 + nres / (W - 2));
        checks++;
        if (edge_x !== ex || edge_y !== ey) begin errors++; $display("FAIL full_coord%0d: got (%0d,%0d) expected (%0d,%0d)", nres, edge_x, edge_y, ex, ey); end
        nres++;
        last_ev = t;
      end
      if (frame_done) begin nfd++; fd_t = t; end
      if (acc) begin
        if (k == 12) t12 = t;
        k++;
      end
    end
    checks++; if (first_se != 1) begin errors++; $display("FAIL full_first_sobel_en: got %0d expected 1", first_se); end
    checks++; if (first_ev != t12 + 2) begin errors++; $display("FAIL full_first_edge: got %0d expected %0d", first_ev, t12 + 2); end
    checks++; if (nres != 6) begin errors++; $display("FAIL full_results: got %0d expected 6", nres); end
    checks++; if (nfd != 1) begin errors++; $display("FAIL full_frame_done_count: got %0d expected 1", nfd); end
    checks++; if (fd_t != last_ev + 2) begin errors++; $display("FAIL full_frame_done_time: got %0d expected %0d", fd_t, last_ev + 2); end
  endtask

  task automatic test_stall();
    int k = 0, t12 = -100, nres = 0, nfd = 0;
    logic r;
    logic [2:0] ex;
    logic [1:0] ey;
    for (int t = 0; t < 50; t++) begin
      r = !(t12 >= 0 && t >= t12 + 2 && t <= t12 + 6);
      tick(k < NP, k == 0, pixval(k), r);
      if (!r) begin
        checks++;
        if (edge_valid !== 1'b1 || edge_x !== 3'd1 || edge_y !== 2'd1 || sobel_en !== 1'b0) begin
          errors++;
          $display("FAIL stall_hold_t%0d: got ev=%b (%0d,%0d) en=%b expected 1 (1,1) 0", t, edge_valid, edge_x, edge_y, sobel_en);
        end
        if (t >= t12 + 3) begin
          checks++;
          if (pix_ready !== 1'b0) begin errors++; $display("FAIL stall_pix_ready_t%0d: got %b expected 0", t, pix_ready); end
        end
      end
      if (t == t12 + 7) begin
        checks++;
        if (stall_cnt !== 32'(5 * STALL_ON)) begin errors++; $display("FAIL stall_cnt: got %0d expected %0d", stall_cnt, 5 * STALL_ON); end
      end
      if (edge_valid && r) begin
        ex = 3'(1 + nres % (W - 2));
        ey = 2'(1 + nres / (W - 2));
        checks++;
        if (edge_x !== ex || edge_y !== ey) begin errors++; $display("FAIL stall_coord%0d: got (%0d,%0d) expected (%0d,%0d)", nres, edge_x, edge_y, ex, ey); end
        nres++;
      end
      if (frame_done) nfd++;
      if (acc) begin
        if (k == 12) t12 = t;
        k++;
      end
    end
    checks++; if (nres != 6) begin errors++; $display("FAIL stall_results: got %0d expected 6", nres); end
    checks++; if (nfd != 1) begin errors++; $display("FAIL stall_frame_done: got %0d expected 1", nfd); end
  endtask

  task automatic test_abort(input int ab);
    int fk = 0, ph = 0, tab = -100, t12 = -100, nerr = 0, terr = -1, nres = 0, nfd = 0;
    logic s;
    logic [7:0] d;
    logic [2:0] ex;
    logic [1:0] ey;
    for (int t = 0; t < 60; t++) begin
      s = (fk == 0) || (ph == 0 && fk == ab);
      d = (ph == 0 && fk == ab) ? pixval(0) : pixval(fk);
      tick((ph == 0) || (fk < NP), s, d, 1'b1);
      if (frame_err) begin nerr++; terr = t; end
      if (t == tab + 1) begin
        checks++;
        if (edge_valid !== 1'b0) begin errors++; $display("FAIL abort%0d_dropped: got edge_valid=%b expected 0", ab, edge_valid); end
      end
      if (t == t12 + 1) begin
        checks++;
        if (PixCol3x1 !== {8'd22, 8'd21, 8'd20}) begin errors++; $display("FAIL abort%0d_pixcol: got %h expected 161514", ab, PixCol3x1); end
      end
      if (edge_valid && tab >= 0 && t > tab) begin
        ex = 3'(1 + nres % (W - 2));
        ey = 2'(1 + nres / (W - 2));
        checks++;
        if (edge_x !== ex || edge_y !== ey) begin errors++; $display("FAIL abort%0d_coord%0d: got (%0d,%0d) expected (%0d,%0d)", ab, nres, edge_x, edge_y, ex, ey); end
        nres++;
      end
      if (frame_done) nfd++;
      if (acc) begin
        if (ph == 0 && fk == ab) begin
          ph = 1; fk = 1; tab = t;
        end else begin
          if (ph == 1 && fk == 12) t12 = t;
          fk++;
        end
      end
    end
    checks++; if (nerr != 1) begin errors++; $display("FAIL abort%0d_err_count: got %0d expected 1", ab, nerr); end
    checks++; if (terr != tab + 1) begin errors++; $display("FAIL abort%0d_err_time: got %0d expected %0d", ab, terr, tab + 1); end
    checks++; if (nres != 6) begin errors++; $display("FAIL abort%0d_results: got %0d expected 6", ab, nres); end
    checks++; if (nfd != 1) begin errors++; $display("FAIL abort%0d_frame_done: got %0d expected 1", ab, nfd); end
  endtask

  task automatic test_random();
    int k = 0, fd = 0, guard = 0, pi, pe;
    int pipe[$];
    int expq[$];
    logic [7:0] img [NP];
    logic [7:0] cur;
    logic v, r, stall_prev;
    logic [2:0] px_prev, ex;
    logic [1:0] py_prev, ey;
    stall_prev = 1'b0;
    px_prev = '0;
    py_prev = '0;
    for (int f = 0; f < NFR; f++)
      for (int y = 1; y < H - 1; y++)
        for (int x = 1; x < W - 1; x++) expq.push_back(y * W + x);
    cur = 8'($urandom);
    while ((k < NFR * NP || fd < NFR) && guard < 4000) begin
      guard++;
      pi = k % NP;
      v  = (k < NFR * NP) && ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 2) != 0);
      tick(v, pi == 0, cur, r);
      if (sobel_en) begin
        checks++;
        if (pipe.size() == 0) begin
          errors++; $display("FAIL rnd_spurious_sobel_en: got 1 expected 0");
        end else begin
          pe = pipe.pop_front();
          if (pe / W >= 2) begin
            checks++;
            if (PixCol3x1 !== {img[pe], img[pe - W], img[pe - 2 * W]}) begin
              errors++; $display("FAIL rnd_pixcol_p%0d: got %h expected %h", pe, PixCol3x1, {img[pe], img[pe - W], img[pe - 2 * W]});
            end
          end
        end
      end
      if (edge_valid && r) begin
        checks++;
        if (expq.size() == 0) begin
          errors++; $display("FAIL rnd_extra_result: got (%0d,%0d) expected none", edge_x, edge_y);
        end else begin
          pe = expq.pop_front();
          ex = 3'(pe % W);
          ey = 2'(pe / W);
          if (edge_x !== ex || edge_y !== ey) begin errors++; $display("FAIL rnd_coord: got (%0d,%0d) expected (%0d,%0d)", edge_x, edge_y, ex, ey); end
        end
      end
      if (edge_valid && !r) begin
        checks++;
        if (sobel_en !== 1'b0) begin errors++; $display("FAIL rnd_stall_sobel_en: got %b expected 0", sobel_en); end
      end
      if (stall_prev) begin
        checks++;
        if (edge_valid !== 1'b1 || edge_x !== px_prev || edge_y !== py_prev) begin
          errors++; $display("FAIL rnd_stall_hold: got %b (%0d,%0d) expected 1 (%0d,%0d)", edge_valid, edge_x, edge_y, px_prev, py_prev);
        end
      end
      stall_prev = edge_valid && !r;
      px_prev = edge_x;
      py_prev = edge_y;
      if (acc) begin
        img[pi] = cur;
        pipe.push_back(pi);
        k++;
        cur = 8'($urandom);
      end
      if (frame_done) fd++;
    end
    checks++; if (guard >= 4000) begin errors++; $display("FAIL rnd_timeout: got %0d frames expected %0d", fd, NFR); end
    checks++; if (expq.size() != 0) begin errors++; $display("FAIL rnd_missing_results: got %0d left expected 0", expq.size()); end
    checks++; if (fd != NFR) begin errors++; $display("FAIL rnd_frame_done: got %0d expected %0d", fd, NFR); end
  endtask

  task automatic test_reset_midframe();
    int  k = 0;
    bit  hit = 0;
    for (int t = 0; t < 40 && !hit; t++) begin
      tick(k < NP, k == 0, pixval(k), 1'b1);
      if (acc) k++;
      if (edge_valid) hit = 1;
    end
    checks++; if (!hit) begin errors++; $display("FAIL rstmid_no_edge: got 0 expected 1"); end
    rst_n = 1'b0;
    #1;
    checks++; if (pix_ready !== 1'b1 || sobel_en !== 1'b0 || edge_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_handshake: got ready=%b en=%b ev=%b expected 1,0,0", pix_ready, sobel_en, edge_valid);
    end
    checks++; if ({edge_x, edge_y} !== 5'd0 || PixCol3x1 !== 24'd0) begin
      errors++; $display("FAIL rstmid_data: got (%0d,%0d) %h expected (0,0) 0", edge_x, edge_y, PixCol3x1);
    end
    checks++; if (frame_done !== 1'b0 || frame_err !== 1'b0 || stall_cnt !== 32'd0) begin
      errors++; $display("FAIL rstmid_flags: got fd=%b fe=%b sc=%0d expected 0,0,0", frame_done, frame_err, stall_cnt);
    end
    pix_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 8; t++) begin
      tick(t < 4, 1'b0, pixval(t + 1), 1'b1);
      checks++;
      if (edge_valid !== 1'b0 || frame_done !== 1'b0 || sobel_en !== 1'b0) begin
        errors++; $display("FAIL rstmid_after_t%0d: got ev=%b fd=%b en=%b expected 0,0,0", t, edge_valid, frame_done, sobel_en);
      end
    end
  endtask

  initial begin
    test_reset();
    test_no_sof();
    test_full_frame();
    test_stall();
    test_abort(7);
    test_abort(14);
    test_random();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sobel_window_ctrl.md
# sobel_window_ctrl

Raster-scan sequencer for the 3x3 Sobel edge datapath. Accepts one pixel per handshake, keeps two line buffers, and presents a vertical 3x1 pixel column plus its enable to the Sobel datapath. Qualifies the datapath's XEdge/YEdge outputs with valid, centre coordinates and backpressure. Sits between the pixel source (camera/DoG front end) and the edge consumer in the SIFT front end.

## Interface
- dataW, 8, pixel width
- imgW, 640, pixels per line (>=3)
- imgH, 480, lines per frame (>=3)
- xW, $clog2(imgW), column coordinate width
- yW, $clog2(imgH), row coordinate width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- pix_valid  in  1  input pixel valid
- pix_sof  in  1  start of frame; qualifies the pixel at (0,0)
- pix_data  in  dataW  pixel value
- pix_ready  out  1  pixel accepted when pix_valid && pix_ready
- PixCol3x1  out  3*dataW  [0+:dataW]=row y-2, [dataW+:dataW]=row y-1, [2*dataW+:dataW]=row y (newest)
- sobel_en  out  1  Sobel datapath enable; one column shift per high cycle
- edge_valid  out  1  datapath XEdge/YEdge hold a valid interior result
- edge_ready  in  1  consumer accepts the result
- edge_x  out  xW  centre column of the current result
- edge_y  out  yW  centre row of the current result
- frame_done  out  1  one-cycle pulse after the last result of a frame is accepted
- frame_err  out  1  one-cycle pulse when pix_sof is accepted mid-frame
- stall_cnt  out  32  backpressure cycle counter (see Configuration)

## Operation
- FSM states: WAIT_SOF, RUN, DRAIN.
- WAIT_SOF: pix_ready=1. Pixels without sof are consumed and discarded. A pixel with sof goes to RUN as pixel (0,0).
- RUN: col counts 0..imgW-1. On wrap, col=0 and row++.
- Accepting pixel (imgW-1, imgH-1) moves the FSM to DRAIN.
- sof accepted in RUN or DRAIN: abort the frame, pulse frame_err, and treat the pixel as (0,0).
  - Pending edge_valid is dropped.
  - Line-buffer contents are not cleared.
- DRAIN: pix_ready=0. Wait until the pipeline is empty and no edge is pending, then pulse frame_done and go to WAIT_SOF.
- Line buffers lb0 (row y-1) and lb1 (row y-2): depth imgW, synchronous read. On accept at column c:
  - read lb0[c] and lb1[c]
  - write lb0[c]<=pix_data and lb1[c]<=old lb0[c]
- Stage-1 register s1 holds pix_data, the read data, col/row and valid. PixCol3x1 comes from s1.
- sobel_en = s1_valid && !(edge_valid && !edge_ready).
- pix_ready = !s1_valid || sobel_en (RUN only).
- Result qualification, when sobel_en fires for column c, row y:
  - qualify iff c>=2 && y>=2
  - then next cycle edge_valid=1, edge_x=c-1, edge_y=y-1
- edge_valid is cleared on edge_ready unless a new qualifying sobel_en fires in the same cycle; in that case it stays 1 with the new coordinates.
- Interior results per frame: (imgW-2)*(imgH-2).
- Border columns/rows still shift the datapath but never raise edge_valid. Rows 0-1 read stale line-buffer data and are suppressed by this rule.

## Timing
- Pixel accepted at cycle t: sobel_en at t+1, edge_valid at t+2 (if qualifying).
- Stalled (edge_valid && !edge_ready): sobel_en=0, so datapath registers and XEdge/YEdge hold. s1 holds. pix_ready=0 once s1 is full.
- Full throughput is one pixel per cycle with edge_ready tied high.
- Reset values:
  - FSM=WAIT_SOF; col=0, row=0
  - s1_valid=0, sobel_en=0
  - edge_valid=0, edge_x=0, edge_y=0
  - frame_done=0, frame_err=0, stall_cnt=0
  - pix_ready=1, PixCol3x1=0
- Reset mid-frame discards everything in flight; next frame requires sof.
- frame_done and frame_err are never high in the same cycle. frame_err takes priority.

## Configuration
- SOBEL_STALL_CNT_EN defined: stall_cnt increments (saturating at 2^32-1) every cycle edge_valid && !edge_ready, and clears on accepted sof.
- SOBEL_STALL_CNT_EN undefined: the counter logic is removed and stall_cnt is tied to 0.

## Structure
- Shared package sobel_pkg: FSM state enum (WAIT_SOF, RUN, DRAIN) and the tap-ordering index constants for PixCol3x1 (TAP_Y2=0, TAP_Y1=1, TAP_Y0=2), also used by the datapath bench.
- Sub-module sobel_line_buf: dual-row, depth-imgW, sync-read/write-first-old buffer with shift-down write. The controller instantiates it once.

## Test plan
- imgW=5, imgH=4, 20 pixels value=col*10+row, edge_ready=1 -> exactly 6 results; coordinates (1,1),(2,1),(3,1),(1,2),(2,2),(3,2); frame_done once, 2 cycles after the last result.
- Same frame, sof pixel at t=0 -> sobel_en at t+1; first edge_valid 2 cycles after accepting (2,2); PixCol3x1 at that column = {22,21,20}.
- edge_ready held low 5 cycles at first result -> edge_valid, edge_x/y, sobel_en=0 stable; pix_ready falls within 1 cycle; stall_cnt=5 (macro on).
- Pixels without sof in WAIT_SOF -> consumed, sobel_en never high, no edge_valid.
- sof at pixel 7 of a frame -> frame_err pulse, pending edge dropped, counters restart; full 6 results follow.
- rst_n low during RUN with edge_valid=1 -> all outputs at reset values immediately; no frame_done.
